// File: rtl/matrix_copro_ctrl_if.sv
// Handshake bundle of the matrix coprocessor controller.
//   instruction / activate_instruction : host request (opcode, address, data, size n)
//   busy / instr_done / error          : host status
//   mem_* / res_sel                    : word-wide memory request/ack channel
//   alu_*                              : matrix ALU request/ack channel
// master = controller side, slave = host + memory + ALU side.
interface matrix_copro_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [31:0]       instruction;
    logic              activate_instruction;
    logic              busy;
    logic              instr_done;
    logic              error;
    logic              mem_start;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic              alu_start;
    logic [3:0]        alu_opcode;
    logic [15:0]       alu_data;
    logic [2:0]        alu_n;
    logic              alu_done;
    logic              res_sel;

    modport master (
        input  instruction, activate_instruction, mem_done, alu_done,
        output busy, instr_done, error,
        output mem_start, mem_wr, mem_addr, mem_wdata, res_sel,
        output alu_start, alu_opcode, alu_data, alu_n
    );

    modport slave (
        output instruction, activate_instruction, mem_done, alu_done,
        input  busy, instr_done, error,
        input  mem_start, mem_wr, mem_addr, mem_wdata, res_sel,
        input  alu_start, alu_opcode, alu_data, alu_n
    );
endinterface

// File: rtl/matrix_copro_ctrl.sv
// Matrix coprocessor sequencer. Accepts one instruction at a time, validates it,
// then either does a single memory access (READ/WRITE) or streams operand A
// (and B for SUM/SUB/MUL) from memory, runs one ALU handshake and writes the
// result words back to the C region.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : matrix_copro_ctrl_if.master (host, memory and ALU channels)
module matrix_copro_ctrl #(
    parameter int DATA_W = 16,
    parameter int ELEM_W = 8,
    parameter int MAX_N  = 5,
    parameter int A_BASE = 0,
    parameter int B_BASE = 16,
    parameter int C_BASE = 32,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_copro_ctrl_if.master bus
);
    localparam int EPW   = DATA_W / ELEM_W;                            // elements per word
    localparam int W_MAX = (MAX_N * MAX_N * ELEM_W + DATA_W - 1) / DATA_W;
    localparam int CNT_W = $clog2(W_MAX + 1);

    localparam logic [3:0] OP_READ  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_SUM   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_DET2  = 4'd9;
    localparam logic [3:0] OP_DET5  = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MEM_OP, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE
    } state_t;

    // Bit 31 of the instruction word carries nothing and is not stored.
    typedef struct packed {
        logic [2:0]  n;
        logic [15:0] data;
        logic [7:0]  addr;
        logic [3:0]  op;
    } instr_t;

    state_t            state_q, state_nxt;
    instr_t            instr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic              mem_start_q, mem_start_nxt;
    logic              mem_wr_q, mem_wr_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
    logic              alu_start_q, alu_start_nxt;
    logic              res_sel_q, res_sel_nxt;

    // ---- decode of the latched instruction ----
    logic             is_det, is_rw, need_b, bad_instr;
    logic [5:0]       n_sq;
    logic [CNT_W-1:0] words, stores;
    logic             ack_mem, ack_alu, last_word, last_store, mem_state;

    assign is_det    = (instr_q.op >= OP_DET2) && (instr_q.op <= OP_DET5);
    assign is_rw     = (instr_q.op == OP_READ) || (instr_q.op == OP_WRITE);
    assign need_b    = (instr_q.op >= OP_SUM) && (instr_q.op <= OP_MUL);
    // DETk is only legal with n == k, i.e. n == op - 7.
    assign bad_instr = (instr_q.op == 4'd0) || (instr_q.op > OP_DET5) ||
                       (instr_q.n == 3'd0) || (32'(instr_q.n) > MAX_N) ||
                       (is_det && ({1'b0, instr_q.n} != instr_q.op - 4'd7));

    assign n_sq   = 6'(instr_q.n) * 6'(instr_q.n);
    assign words  = CNT_W'((32'(n_sq) + EPW - 1) / EPW);
    assign stores = is_det ? CNT_W'(1) : words;

    // Acks only count while the matching request is actually outstanding.
    assign ack_mem    = mem_start_q & bus.mem_done;
    assign ack_alu    = alu_start_q & bus.alu_done;
    assign last_word  = (cnt_q == words - CNT_W'(1));
    assign last_store = (cnt_q == stores - CNT_W'(1));
    assign mem_state  = (state_q == S_MEM_OP) || (state_q == S_LOAD_A) ||
                        (state_q == S_LOAD_B) || (state_q == S_STORE);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    // ---- next state ----
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.activate_instruction) state_nxt = S_DECODE;
            S_DECODE: begin
                if (bad_instr)  state_nxt = S_IDLE;
                else if (is_rw) state_nxt = S_MEM_OP;
                else            state_nxt = S_LOAD_A;
            end
            S_MEM_OP: if (ack_mem) state_nxt = S_IDLE;
            S_LOAD_A: if (ack_mem && last_word) state_nxt = need_b ? S_LOAD_B : S_EXEC;
            S_LOAD_B: if (ack_mem && last_word) state_nxt = S_EXEC;
            S_EXEC:   if (ack_alu) state_nxt = S_STORE;
            S_STORE:  if (ack_mem && last_store) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---- outputs (next values of the registered outputs) ----
    always_comb begin
        mem_start_nxt = 1'b0;
        mem_addr_nxt  = mem_addr_q;
        mem_wr_nxt    = mem_wr_q;
        mem_wdata_nxt = mem_wdata_q;
        if (mem_start_q) begin
            // Hold the request until acked; dropping it forces one idle cycle.
            mem_start_nxt = !bus.mem_done;
            if (bus.mem_done) mem_wr_nxt = 1'b0;
        end else if (mem_state) begin
            mem_start_nxt = 1'b1;
            mem_wdata_nxt = DATA_W'(instr_q.data);
            case (state_q)
                S_MEM_OP: begin
                    mem_addr_nxt = ADDR_W'(instr_q.addr);
                    mem_wr_nxt   = (instr_q.op == OP_WRITE);
                end
                S_LOAD_A: begin
                    mem_addr_nxt = ADDR_W'(A_BASE) + ADDR_W'(cnt_q);
                    mem_wr_nxt   = 1'b0;
                end
                S_LOAD_B: begin
                    mem_addr_nxt = ADDR_W'(B_BASE) + ADDR_W'(cnt_q);
                    mem_wr_nxt   = 1'b0;
                end
                default: begin
                    mem_addr_nxt = ADDR_W'(C_BASE) + ADDR_W'(cnt_q);
                    mem_wr_nxt   = 1'b1;
                end
            endcase
        end

        alu_start_nxt = alu_start_q ? !bus.alu_done : (state_q == S_EXEC);
        busy_nxt      = (state_nxt != S_IDLE);
        done_nxt      = ((state_q == S_MEM_OP) && ack_mem) ||
                        ((state_q == S_STORE) && ack_mem && last_store);
        err_nxt       = (state_q == S_DECODE) && bad_instr;
        res_sel_nxt   = (state_nxt == S_STORE);

        // Cleared on every state change; the last word always changes state,
        // so the count never runs past W-1.
        cnt_nxt = cnt_q;
        if (state_nxt != state_q) cnt_nxt = '0;
        else if (ack_mem)         cnt_nxt = cnt_q + CNT_W'(1);
    end

    // ---- output / datapath registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_start_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            alu_start_q <= 1'b0;
            res_sel_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && bus.activate_instruction)
                instr_q <= instr_t'(bus.instruction[30:0]);
            cnt_q       <= cnt_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
            mem_start_q <= mem_start_nxt;
            mem_wr_q    <= mem_wr_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            alu_start_q <= alu_start_nxt;
            res_sel_q   <= res_sel_nxt;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.instr_done = done_q;
    assign bus.error      = err_q;
    assign bus.mem_start  = mem_start_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.res_sel    = res_sel_q;
    assign bus.alu_start  = alu_start_q;
    assign bus.alu_opcode = instr_q.op;
    assign bus.alu_data   = instr_q.data;
    assign bus.alu_n      = instr_q.n;
endmodule

// File: doc/matrix_copro_ctrl.md
MATRIX_COPRO_CTRL -- requirements
Module: matrix_copro_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: memory word width in bits.
REQ-002 SHALL have parameter ELEM_W, default 8: matrix element width; DATA_W SHALL be a multiple of ELEM_W.
REQ-003 SHALL have parameter MAX_N, default 5: largest square matrix dimension, range 2..7.
REQ-004 SHALL have parameters A_BASE=0, B_BASE=16, C_BASE=32, default ADDR_W=8: region base addresses and address width.
REQ-005 Ports: clk  in  1  single clock, rising edge.
REQ-006 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Ports: instruction  in  32  [3:0] opcode, [11:4] address, [27:12] data, [30:28] size n.
REQ-008 Ports: activate_instruction  in  1  one-cycle request to accept instruction.
REQ-009 Ports: busy  out  1  high from acceptance until completion.
REQ-010 Ports: instr_done  out  1  one-cycle pulse on completion.
REQ-011 Ports: error  out  1  one-cycle pulse on rejected instruction.
REQ-012 Ports: mem_start out 1, mem_wr out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_done in 1: memory handshake.
REQ-013 Ports: alu_start out 1, alu_opcode out 4, alu_data out 16, alu_n out 3, alu_done in 1: ALU handshake.
REQ-014 Ports: res_sel out 1: high while stored words come from the ALU result (mem_wdata muxed externally); low selects instruction data.

Function
REQ-015 Opcodes: 1 READ, 2 WRITE, 3 SUM, 4 SUB, 5 MUL, 6 TRANSP, 7 OPST, 8 MULSCL, 9..12 DET2..DET5; all others illegal.
REQ-016 States: IDLE, DECODE, MEM_OP, LOAD_A, LOAD_B, EXEC, STORE; encoding free.
REQ-017 IDLE: on activate_instruction latch instruction, set busy next cycle, go DECODE; activate_instruction while busy SHALL be ignored.
REQ-018 DECODE, one cycle: illegal opcode, n=0, n>MAX_N, or DETk with k!=n -> error pulse, busy low, IDLE; READ/WRITE -> MEM_OP; else -> LOAD_A.
REQ-019 Words per matrix W = ceil(n*n*ELEM_W/DATA_W); n=5, ELEM_W=8, DATA_W=16 gives W=13.
REQ-020 Memory access: mem_start held high with mem_addr, mem_wr, mem_wdata stable until the cycle mem_done is sampled high; mem_start SHALL be low at least one cycle between accesses.
REQ-021 MEM_OP: one access at instruction address; mem_wr=1 for WRITE with res_sel=0; on mem_done -> instr_done, IDLE.
REQ-022 LOAD_A: read A_BASE..A_BASE+W-1 in order; then LOAD_B for SUM/SUB/MUL, else EXEC.
REQ-023 LOAD_B: read B_BASE..B_BASE+W-1 in order, then EXEC.
REQ-024 EXEC: alu_start high with alu_opcode, alu_data, alu_n stable until alu_done sampled high, then STORE.
REQ-025 STORE: res_sel=1, mem_wr=1, write C_BASE..C_BASE+S-1, S=1 for DET ops, else S=W; then instr_done pulse, busy low, IDLE.
REQ-026 Word counter SHALL be ceil(log2(ceil(MAX_N*MAX_N*ELEM_W/DATA_W)+1)) bits, cleared on every state entry; no wrap past W-1.
REQ-027 mem_done or alu_done outside an active request SHALL be ignored.
REQ-028 Start signals SHALL be registered outputs.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and clear busy, instr_done, error, mem_start, mem_wr, res_sel, alu_start, mem_addr, counters, latched instruction to 0.
REQ-030 Reset mid-operation SHALL abandon the operation; no access SHALL be issued after release until a new instruction is accepted.
REQ-031 First instruction SHALL be accepted on the first activate_instruction after rst_n rises.

Verification
REQ-032 WRITE addr=0x05 data=0xBEEF, mem_done after 2 cycles -> one access, mem_wr=1, mem_wdata=0xBEEF, res_sel=0, instr_done once, busy low.
REQ-033 SUM n=5 -> reads 0..12 then 16..28, one ALU handshake, writes 32..44; exactly 39 memory accesses.
REQ-034 TRANSP n=3 -> W=5: reads 0..4 only, no LOAD_B, writes 32..36.
REQ-035 DET3 n=3 -> reads 0..4, one write to 32; DET4 with n=3 -> error pulse, no memory access.
REQ-036 Opcode 0xE, and n=0 -> error pulse each, busy low within 2 cycles of acceptance.
REQ-037 rst_n low during LOAD_B of MUL -> all outputs 0 same cycle; after release no mem_start until new activate_instruction.
